// File: rtl/reg_file_if.sv
// reg_file_if: commander/ROB-facing bundle of the architectural register file.
//   master : driven by the commander/ROB side (source/dest indices, rename,
//            commit and rollback strobes); receives operand tag/value.
//   slave  : the register file itself.
// clk, rst and rdy are not part of the bundle; they stay plain ports.
interface reg_file_if #(
    parameter int REG_POS_W = 5,
    parameter int DATA_W    = 32,
    parameter int ROB_ID_W  = 5
);
    // operand read
    logic [REG_POS_W-1:0] rs1_from_cmd;
    logic [REG_POS_W-1:0] rs2_from_cmd;
    logic [ROB_ID_W-1:0]  Q1_to_cmd;
    logic [ROB_ID_W-1:0]  Q2_to_cmd;
    logic [DATA_W-1:0]    V1_to_cmd;
    logic [DATA_W-1:0]    V2_to_cmd;
    // dispatch rename
    logic                 enable_sign_from_cmd;
    logic [REG_POS_W-1:0] rd_from_cmd;
    logic [ROB_ID_W-1:0]  rob_id_from_cmd;
    // ROB commit / flush
    logic                 commit_sign;
    logic [REG_POS_W-1:0] rd_from_rob;
    logic [ROB_ID_W-1:0]  Q_from_rob;
    logic [DATA_W-1:0]    V_from_rob;
    logic                 rollback_sign;

    modport master (
        output rs1_from_cmd, rs2_from_cmd,
        input  Q1_to_cmd, Q2_to_cmd, V1_to_cmd, V2_to_cmd,
        output enable_sign_from_cmd, rd_from_cmd, rob_id_from_cmd,
        output commit_sign, rd_from_rob, Q_from_rob, V_from_rob,
        output rollback_sign
    );

    modport slave (
        input  rs1_from_cmd, rs2_from_cmd,
        output Q1_to_cmd, Q2_to_cmd, V1_to_cmd, V2_to_cmd,
        input  enable_sign_from_cmd, rd_from_cmd, rob_id_from_cmd,
        input  commit_sign, rd_from_rob, Q_from_rob, V_from_rob,
        input  rollback_sign
    );
endinterface

// File: rtl/reg_file.sv
// reg_file: 32 x DATA_W architectural register file with per-register ROB
// rename tags (Q). x0 is hardwired to zero (tag 0, value 0).
// Ports:
//   clk  - clock
//   rst  - asynchronous active-high reset (clears all data and tags)
//   rdy  - global ready; low freezes all state, reads stay live
//   bus  - reg_file_if.slave: rs1/rs2 combinational reads (Q/V), dispatch
//          rename (enable/rd/rob_id), ROB commit (rd/Q/V) and rollback.
// Optional macro REG_COMMIT_BYPASS_EN: read ports forward a same-cycle commit
// whose tag still matches the stored tag (Q reads 0, V reads commit value).
module reg_file #(
    parameter int REG_NUM   = 32,
    parameter int REG_POS_W = 5,
    parameter int DATA_W    = 32,
    parameter int ROB_ID_W  = 5
) (
    input logic       clk,
    input logic       rst,
    input logic       rdy,
    reg_file_if.slave bus
);

    logic [DATA_W-1:0]   data [REG_NUM];
    logic [ROB_ID_W-1:0] q    [REG_NUM];

    logic commit_ok;
    logic rename_ok;
    logic tag_match;

    assign commit_ok = bus.commit_sign && (bus.rd_from_rob != '0);
    assign rename_ok = bus.enable_sign_from_cmd && (bus.rd_from_cmd != '0);
    assign tag_match = (q[bus.rd_from_rob] == bus.Q_from_rob);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < REG_NUM; i++) begin
                data[i] <= '0;
                q[i]    <= '0;
            end
        end else if (rdy) begin
            // The commit data write survives a rollback: the mispredicted
            // jump's link register must still land.
            if (commit_ok)
                data[bus.rd_from_rob] <= bus.V_from_rob;

            if (bus.rollback_sign) begin
                for (int unsigned i = 0; i < REG_NUM; i++)
                    q[i] <= '0;
            end else begin
                // A stale commit (younger rename present) keeps the tag.
                if (commit_ok && tag_match)
                    q[bus.rd_from_rob] <= '0;
                // Rename is placed last so it wins on a same-rd collision.
                if (rename_ok)
                    q[bus.rd_from_cmd] <= bus.rob_id_from_cmd;
            end
        end
    end

`ifdef REG_COMMIT_BYPASS_EN
    logic hit1;
    logic hit2;

    assign hit1 = commit_ok && rdy && (bus.rs1_from_cmd == bus.rd_from_rob)
                  && (q[bus.rs1_from_cmd] == bus.Q_from_rob);
    assign hit2 = commit_ok && rdy && (bus.rs2_from_cmd == bus.rd_from_rob)
                  && (q[bus.rs2_from_cmd] == bus.Q_from_rob);
`endif

    always_comb begin
        bus.Q1_to_cmd = q[bus.rs1_from_cmd];
        bus.V1_to_cmd = data[bus.rs1_from_cmd];
        bus.Q2_to_cmd = q[bus.rs2_from_cmd];
        bus.V2_to_cmd = data[bus.rs2_from_cmd];
`ifdef REG_COMMIT_BYPASS_EN
        if (hit1) begin
            bus.Q1_to_cmd = '0;
            bus.V1_to_cmd = bus.V_from_rob;
        end
        if (hit2) begin
            bus.Q2_to_cmd = '0;
            bus.V2_to_cmd = bus.V_from_rob;
        end
`endif
        if (bus.rs1_from_cmd == '0) begin
            bus.Q1_to_cmd = '0;
            bus.V1_to_cmd = '0;
        end
        if (bus.rs2_from_cmd == '0) begin
            bus.Q2_to_cmd = '0;
            bus.V2_to_cmd = '0;
        end
    end

endmodule

// File: tb/tb_reg_file.sv
// tb_reg_file: self-checking bench for reg_file. A behavioural model (plain
// arrays of values and tags updated by the register-file rules) is compared
// against both read ports on every falling edge; directed sequences pin the
// model with literal expectations, then a randomized phase exercises it.
module tb_reg_file;

    localparam int REG_NUM   = 32;
    localparam int REG_POS_W = 5;
    localparam int DATA_W    = 32;
    localparam int ROB_ID_W  = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rdy = 1'b1;

    reg_file_if #(.REG_POS_W(REG_POS_W), .DATA_W(DATA_W), .ROB_ID_W(ROB_ID_W)) bus ();

    reg_file #(
        .REG_NUM  (REG_NUM),
        .REG_POS_W(REG_POS_W),
        .DATA_W   (DATA_W),
        .ROB_ID_W (ROB_ID_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .rdy(rdy),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // ---------------- model ----------------
    logic [DATA_W-1:0]   m_data [REG_NUM];
    logic [ROB_ID_W-1:0] m_q    [REG_NUM];

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, got, exp, $time);
    endtask

    task automatic model_reset();
        for (int i = 0; i < REG_NUM; i++) begin
            m_data[i] = '0;
            m_q[i]    = '0;
        end
    endtask

    // Apply one clock edge's worth of architectural effects from current inputs.
    task automatic model_step();
        int c_rd;
        int r_rd;
        logic clear_tag;
        if (rst || !rdy) return;
        c_rd = int'(bus.rd_from_rob);
        r_rd = int'(bus.rd_from_cmd);
        clear_tag = bus.commit_sign && c_rd != 0 && m_q[c_rd] == bus.Q_from_rob;
        if (bus.commit_sign && c_rd != 0) m_data[c_rd] = bus.V_from_rob;
        if (bus.rollback_sign) begin
            for (int i = 0; i < REG_NUM; i++) m_q[i] = '0;
        end else begin
            if (clear_tag) m_q[c_rd] = '0;
            if (bus.enable_sign_from_cmd && r_rd != 0) m_q[r_rd] = bus.rob_id_from_cmd;
        end
    endtask

    task automatic exp_read(input logic [4:0] rs, output logic [4:0] eq, output logic [31:0] ev);
        int r;
        r  = int'(rs);
        eq = m_q[r];
        ev = m_data[r];
`ifdef REG_COMMIT_BYPASS_EN
        if (!rst && rdy && bus.commit_sign && bus.rd_from_rob == rs && rs != 0
            && m_q[r] == bus.Q_from_rob) begin
            eq = '0;
            ev = bus.V_from_rob;
        end
`endif
        if (rst || r == 0) begin
            eq = '0;
            ev = '0;
        end
    endtask

    // Compare process: both read ports checked every falling edge.
    always @(negedge clk) begin
        logic [4:0]  eq1, eq2;
        logic [31:0] ev1, ev2;
        exp_read(bus.rs1_from_cmd, eq1, ev1);
        exp_read(bus.rs2_from_cmd, eq2, ev2);
        chk("cyc_Q1", 32'(bus.Q1_to_cmd), 32'(eq1));
        chk("cyc_V1", bus.V1_to_cmd, ev1);
        chk("cyc_Q2", 32'(bus.Q2_to_cmd), 32'(eq2));
        chk("cyc_V2", bus.V2_to_cmd, ev2);
    end

    // Illegal stimulus guard: a commit always carries a real ROB id.
    always @(posedge clk) begin
        assert (!(bus.commit_sign && bus.Q_from_rob == '0))
            else $error("FAIL illegal_commit_q0: commit with Q_from_rob=0");
    end

    // ---------------- stimulus ----------------
    task automatic idle_ctrl();
        bus.enable_sign_from_cmd = 1'b0;
        bus.rd_from_cmd          = '0;
        bus.rob_id_from_cmd      = '0;
        bus.commit_sign          = 1'b0;
        bus.rd_from_rob          = '0;
        bus.Q_from_rob           = 5'd1;
        bus.V_from_rob           = '0;
        bus.rollback_sign        = 1'b0;
    endtask

    // Drive one cycle of controls, clock it, update model, return to idle.
    task automatic step(input logic en, input logic [4:0] rd, input logic [4:0] rid,
                        input logic cm, input logic [4:0] crd, input logic [4:0] cq,
                        input logic [31:0] cv, input logic rb);
        bus.enable_sign_from_cmd = en;
        bus.rd_from_cmd          = rd;
        bus.rob_id_from_cmd      = rid;
        bus.commit_sign          = cm;
        bus.rd_from_rob          = crd;
        bus.Q_from_rob           = cq;
        bus.V_from_rob           = cv;
        bus.rollback_sign        = rb;
        @(posedge clk);
        #1;
        model_step();
        idle_ctrl();
    endtask

    task automatic rd1(input logic [4:0] rs, input string name,
                       input logic [4:0] eq, input logic [31:0] ev);
        bus.rs1_from_cmd = rs;
        #1;
        chk({name, "_Q1"}, 32'(bus.Q1_to_cmd), 32'(eq));
        chk({name, "_V1"}, bus.V1_to_cmd, ev);
    endtask

    task automatic rd2(input logic [4:0] rs, input string name,
                       input logic [4:0] eq, input logic [31:0] ev);
        bus.rs2_from_cmd = rs;
        #1;
        chk({name, "_Q2"}, 32'(bus.Q2_to_cmd), 32'(eq));
        chk({name, "_V2"}, bus.V2_to_cmd, ev);
    endtask

    initial begin
        model_reset();
        idle_ctrl();
        bus.rs1_from_cmd = '0;
        bus.rs2_from_cmd = '0;
        #2;
        rd1(5'd5, "por", 5'd0, 32'h0);
        #10 rst = 1'b0;

        // Async reset mid-cycle with x5=0x1234, Q[5]=3.
        step(1'b0, 5'd0, 5'd0, 1'b1, 5'd5, 5'd1, 32'h1234, 1'b0);
        step(1'b1, 5'd5, 5'd3, 1'b0, 5'd0, 5'd1, 32'h0, 1'b0);
        rd1(5'd5, "pre_rst", 5'd3, 32'h1234);
        #1 rst = 1'b1;
        model_reset();
        #1;
        chk("async_rst_Q1", 32'(bus.Q1_to_cmd), 32'h0);
        chk("async_rst_V1", bus.V1_to_cmd, 32'h0);
        @(negedge clk);
        #1 rst = 1'b0;

        // Rename then commit.
        step(1'b1, 5'd5, 5'd3, 1'b0, 5'd0, 5'd1, 32'h0, 1'b0);
        rd1(5'd5, "renamed", 5'd3, 32'h0);
        step(1'b0, 5'd0, 5'd0, 1'b1, 5'd5, 5'd3, 32'hDEADBEEF, 1'b0);
        rd1(5'd5, "committed", 5'd0, 32'hDEADBEEF);

        // Stale commit keeps the younger tag.
        step(1'b1, 5'd7, 5'd2, 1'b0, 5'd0, 5'd1, 32'h0, 1'b0);
        step(1'b1, 5'd7, 5'd4, 1'b0, 5'd0, 5'd1, 32'h0, 1'b0);
        step(1'b0, 5'd0, 5'd0, 1'b1, 5'd7, 5'd2, 32'h11, 1'b0);
        rd1(5'd7, "stale", 5'd4, 32'h11);

        // Same-cycle commit + rename on x9: rename wins the tag.
        step(1'b1, 5'd9, 5'd1, 1'b0, 5'd0, 5'd1, 32'h0, 1'b0);
        step(1'b1, 5'd9, 5'd6, 1'b1, 5'd9, 5'd1, 32'h55, 1'b0);
        rd2(5'd9, "cm_rn_same", 5'd6, 32'h55);

        // Commit and rename to different rds both apply.
        step(1'b1, 5'd10, 5'd8, 1'b1, 5'd7, 5'd4, 32'h77, 1'b0);
        rd1(5'd7, "cm_diff", 5'd0, 32'h77);
        rd2(5'd10, "rn_diff", 5'd8, 32'h0);

        // Rollback with commit; same-cycle rename discarded.
        step(1'b1, 5'd1, 5'd2, 1'b0, 5'd0, 5'd1, 32'h0, 1'b0);
        step(1'b1, 5'd3, 5'd5, 1'b0, 5'd0, 5'd1, 32'h0, 1'b0);
        rd2(5'd3, "pre_rb", 5'd5, 32'h0);
        step(1'b1, 5'd4, 5'd7, 1'b1, 5'd1, 5'd2, 32'h80, 1'b1);
        rd1(5'd1, "rb_x1", 5'd0, 32'h80);
        rd2(5'd4, "rb_x4", 5'd0, 32'h0);
        rd1(5'd3, "rb_x3", 5'd0, 32'h0);
        rd2(5'd9, "rb_x9", 5'd0, 32'h55);

        // x0 is immutable.
        step(1'b1, 5'd0, 5'd5, 1'b1, 5'd0, 5'd1, 32'hFF, 1'b0);
        rd1(5'd0, "x0", 5'd0, 32'h0);

        // rdy low freezes state.
        rdy = 1'b0;
        step(1'b1, 5'd2, 5'd3, 1'b1, 5'd2, 5'd3, 32'h99, 1'b0);
        rdy = 1'b1;
        rd2(5'd2, "rdy_low", 5'd0, 32'h0);

        // Commit read in the same cycle as the commit.
        step(1'b1, 5'd5, 5'd3, 1'b0, 5'd0, 5'd1, 32'h0, 1'b0);
        bus.commit_sign = 1'b1;
        bus.rd_from_rob = 5'd5;
        bus.Q_from_rob  = 5'd3;
        bus.V_from_rob  = 32'hAB;
`ifdef REG_COMMIT_BYPASS_EN
        rd2(5'd5, "bypass", 5'd0, 32'hAB);
`else
        rd2(5'd5, "no_bypass", 5'd3, 32'hDEADBEEF);
`endif
        step(1'b0, 5'd0, 5'd0, 1'b1, 5'd5, 5'd3, 32'hAB, 1'b0);
        rd2(5'd5, "after_cm", 5'd0, 32'hAB);

        // Randomized phase; small index range forces collisions.
        for (int n = 0; n < 3000; n++) begin
            logic [4:0]  crd, cq;
            crd = 5'($urandom_range(0, 11));
            if ($urandom_range(0, 1) == 1 && m_q[int'(crd)] != '0) cq = m_q[int'(crd)];
            else cq = 5'($urandom_range(1, 31));
            bus.rs1_from_cmd = 5'($urandom_range(0, 11));
            bus.rs2_from_cmd = 5'($urandom_range(0, 11));
            rdy = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 199) == 0) begin
                #1 rst = 1'b1;
                model_reset();
                #1 rst = 1'b0;
            end
            step(1'($urandom_range(0, 1)), 5'($urandom_range(0, 11)),
                 5'($urandom_range(1, 31)), 1'($urandom_range(0, 1)), crd, cq,
                 $urandom, ($urandom_range(0, 29) == 0));
        end

        rdy = 1'b1;
        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/reg_file.md
Name: reg_file

Overview:
- Architectural register file with rename tags: 32 x 32-bit registers, each with a ROB tag (Q) naming the in-flight instruction that will produce it.
- Sits downstream of the ROB and consumes its commit stream (commit_sign, rd/Q/V) and rollback_sign.
- Sits beside the commander: supplies operand value or producing ROB id for rs1/rs2, and records the new rd tag on dispatch.

Parameters:
- REG_NUM, 32, number of architectural registers (x0 hardwired zero)
- REG_POS_W, 5, register index width
- DATA_W, 32, register data width
- ROB_ID_W, 5, ROB id width; id 0 = INVALID_ROB, valid ids are 1..ROB_SIZE

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- rdy  in  1  global ready; low freezes all state
- rs1_from_cmd  in  REG_POS_W  source register 1 index
- rs2_from_cmd  in  REG_POS_W  source register 2 index
- Q1_to_cmd  out  ROB_ID_W  producing ROB id of rs1, 0 if value is architectural
- Q2_to_cmd  out  ROB_ID_W  producing ROB id of rs2, 0 if value is architectural
- V1_to_cmd  out  DATA_W  value of rs1 (meaningful when Q1_to_cmd==0)
- V2_to_cmd  out  DATA_W  value of rs2 (meaningful when Q2_to_cmd==0)
- enable_sign_from_cmd  in  1  dispatch: rename rd_from_cmd to rob_id_from_cmd
- rd_from_cmd  in  REG_POS_W  destination of the dispatched instruction
- rob_id_from_cmd  in  ROB_ID_W  ROB id given to the dispatched instruction
- commit_sign  in  1  ROB commit strobe
- rd_from_rob  in  REG_POS_W  committed destination
- Q_from_rob  in  ROB_ID_W  committed ROB id
- V_from_rob  in  DATA_W  committed value
- rollback_sign  in  1  ROB misprediction flush

Behaviour:
- State: data[0..31] (DATA_W) and Q[0..31] (ROB_ID_W).
- Reset (async, rst=1): all data=0, all Q=0. All outputs are combinational reads, so they read 0 immediately.
- rdy=0 (rst low): no state changes; reads stay live.
- Read, combinational, no latency:
  - Qn_to_cmd = Q[rsn]; Vn_to_cmd = data[rsn].
  - rs=0 always returns Q=0, V=0.
- Commit (posedge, rdy=1, commit_sign=1, rd_from_rob!=0):
  - data[rd_from_rob] <= V_from_rob.
  - Q[rd_from_rob] <= 0 only if Q[rd_from_rob]==Q_from_rob. A mismatch means a younger rename exists; Q is kept.
  - rd_from_rob=0: no effect. Stores and branches carry rd=0.
- Rename (posedge, rdy=1, enable_sign_from_cmd=1, rd_from_cmd!=0, rollback_sign=0):
  - Q[rd_from_cmd] <= rob_id_from_cmd.
  - rd=0 is ignored.
- Simultaneous commit and rename to the same rd: the data write happens and the rename tag wins; Q ends as rob_id_from_cmd.
- Commit and rename to different rds in the same cycle: both apply independently.
- Rollback (posedge, rdy=1, rollback_sign=1):
  - All Q <= 0; data is kept.
  - A commit in the same cycle still writes data. The ROB asserts commit_sign together with rollback_sign for the mispredicted jump, so its rd (e.g. jal/jalr link) must land.
  - Any rename in the same cycle is discarded.
- Writes are visible on read ports the cycle after the edge, except where REG_COMMIT_BYPASS_EN applies.
- Q_from_rob=0 with commit_sign=1 is illegal input; the bench asserts it never occurs.

Optional Feature:
- REG_COMMIT_BYPASS_EN defined:
  - Read ports forward the same-cycle commit. If commit_sign && rdy && rd_from_rob!=0 && rsn==rd_from_rob && Q[rsn]==Q_from_rob, then Vn_to_cmd=V_from_rob and Qn_to_cmd=0.
  - This closes the window where the ROB entry is freed the same cycle the commander reads the tag.
- Undefined: reads show stored state only.
  - The commander sees the stale tag for one cycle. Correctness relies on the ROB ready lookup or on re-dispatch next cycle.

Test Plan:
- Reset: assert rst asynchronously mid-cycle with x5=0x1234, Q[5]=3 -> Q1/V1 for rs1=5 read 0/0 before the next clk edge.
- Rename then commit: dispatch rd=5, rob_id=3; next cycle rs1=5 -> Q1=3. Commit rd=5, Q=3, V=0xDEADBEEF -> next cycle Q1=0, V1=0xDEADBEEF.
- Stale commit: rename x7->2, then x7->4, then commit rd=7, Q=2, V=0x11 -> data[7]=0x11, Q[7] stays 4.
- Same-cycle commit+rename on x9 (commit Q=1, V=0x55; rename id=6) -> Q[9]=6, data[9]=0x55.
- Rollback with commit: Q[1]=2, Q[3]=5; same edge commit rd=1, Q=2, V=0x80 plus rollback plus rename x4->7 -> all Q=0, data[1]=0x80, x4 not renamed.
- x0 and rdy: rename rd=0 and commit rd=0, V=0xFF -> rs=0 reads 0/0. With rdy=0, rename x2->3 -> Q[2] unchanged. Bypass build: commit rd=5, Q=3, V=0xAB while reading rs2=5 -> same cycle Q2=0, V2=0xAB.
